axis_fifo_param: RTL

- Parametrised AXI-Stream FIFO; successor to the single-beat master/slave valid/ready handshake.
- Decouples an AXIS producer from an AXIS consumer through DEPTH beats of storage, with configurable data width and TLAST pass-through.
- Sustains one beat per clock in both directions, and reports occupancy and an almost-full flag for upstream flow control.

---
 rtl/axis_pkg.sv | 32 +++
 rtl/axis_fifo_mem.sv | 32 +++
 rtl/axis_fifo_param.sv | 124 ++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared defaults, sizing helper and beat layout for the AXI-Stream FIFO.
package axis_pkg;

  // Default build of the FIFO: byte-wide stream, 16 beats, early warning at 12.
  localparam int AXIS_DATA_WIDTH = 8;
  localparam int AXIS_DEPTH      = 16;
  localparam int AXIS_AF_THRESH  = 12;

  // One stored beat at the default width; tlast sits above tdata so a beat
  // packs into a single (DATA_WIDTH+1)-bit storage word.
  typedef struct packed {
    logic                       tlast;
    logic [AXIS_DATA_WIDTH-1:0] tdata;
  } axis_beat_t;

  // Number of address bits needed for 'value' entries, never less than 1 so
  // a degenerate depth still yields a legal vector width.
  function automatic int clog2_min1(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

  // Storage word width for a beat of the given data width.
  function automatic int beat_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// The asynchronous read lets the FIFO present its head beat in the same
// cycle the read pointer moves (first-word-fall-through).
module axis_fifo_mem
  import axis_pkg::*;
#(
  parameter int WIDTH  = beat_width(AXIS_DATA_WIDTH),
  parameter int DEPTH  = AXIS_DEPTH,
  parameter int ADDR_W = clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  // Contents are never reset; the FIFO pointers decide what is valid.
  logic [WIDTH-1:0] mem_reg [DEPTH];

  // Write port: one word per clock when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // Read port is combinational from the current read address.
  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/axis_fifo_param.sv
// Parametrised AXI-Stream FIFO with first-word-fall-through output,
// occupancy count and almost-full flag. TLAST is carried untouched.
module axis_fifo_param
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int DEPTH      = AXIS_DEPTH,
  parameter int AF_THRESH  = AXIS_AF_THRESH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    almost_full
);

  localparam int PTR_W  = clog2_min1(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int BEAT_W = beat_width(DATA_WIDTH);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF    = CNT_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  // Beat layout at this instance's data width.
  typedef struct packed {
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;
  } beat_t;

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg,  count_next;
  logic             s_ready_reg, s_ready_next;
  logic             m_valid_reg, m_valid_next;
  logic             af_reg,      af_next;

  logic             push;
  logic             pop;
  beat_t            wr_beat;
  beat_t            rd_beat;
  logic [BEAT_W-1:0] rd_word;

  // Handshakes use only registered ready/valid, so neither side's ready
  // depends combinationally on its own valid.
  assign push = s_axis_tvalid && s_ready_reg;
  assign pop  = m_valid_reg && m_axis_tready;

  assign wr_beat.tlast = s_axis_tlast;
  assign wr_beat.tdata = s_axis_tdata;

  axis_fifo_mem #(
    .WIDTH  (BEAT_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_reg),
    .wdata (wr_beat),
    .raddr (rd_ptr_reg),
    .rdata (rd_word)
  );

  assign rd_beat = beat_t'(rd_word);

  // Next-state for pointers, occupancy and the registered flags. The flags
  // are computed from the post-update count so they are exact on every cycle.
  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end
    unique case ({push, pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
    s_ready_next = (count_next < CNT_DEPTH);
    m_valid_next = (count_next != CNT_ZERO);
    af_next      = (count_next >= CNT_AF);
  end

  // State registers; reset discards every stored beat and closes both ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      s_ready_reg <= 1'b0;
      m_valid_reg <= 1'b0;
      af_reg      <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      s_ready_reg <= s_ready_next;
      m_valid_reg <= m_valid_next;
      af_reg      <= af_next;
    end
  end

  assign s_axis_tready = s_ready_reg;
  assign m_axis_tvalid = m_valid_reg;
  assign m_axis_tdata  = rd_beat.tdata;
  assign m_axis_tlast  = rd_beat.tlast;
  assign count         = count_reg;
  assign almost_full   = af_reg;

endmodule
